time_keeper_multi: RTL and testbench
====================================

# time_keeper_multi

Parametrised successor to the board's clock/timer counter. Keeps three independent time banks (wall clock, countdown timer, stopwatch) that all run in the background and presents the bank selected by the mode input to the display path. Fields never hold out-of-range values, and timer expiry is flagged with a single pulse. Sits between the 1 Hz tick divider / button synchroniser and the 7-segment encoder.

## Interface
- W, 6, width of each time field
- SEC_MOD, 60, modulus of seconds and minutes fields
- HOUR_MOD, 24, modulus of hours field (2..2^W)

- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-low reset
- i_tick  in  1  one-cycle 1 Hz strobe, synchronous to i_clk
- i_mode  in  2  0 clock, 1 timer, 2 stopwatch, 3 clock view (set disabled)
- i_set  in  1  level; edit the bank selected by i_mode
- i_sel  in  2  field select in set: 0 sec, 1 min, 2 hour, 3 none
- i_up  in  1  synchronised button level; rising edge increments
- i_down  in  1  synchronised button level; rising edge decrements
- i_start  in  1  synchronised button level; rising edge toggles run flag of selected bank
- i_clear  in  1  synchronised button level; rising edge zeroes selected bank
- o_hour, o_min, o_sec  out  W each  fields of displayed bank
- o_running  out  1  run flag of displayed bank (0 in modes 0/3)
- o_timer_done  out  1  one-cycle expiry pulse

## Operation
- Edge detect: per button, a previous-value register; edge = level & ~prev. The edge is registered; the action happens on the following clock edge.
- Clock bank: on i_tick, sec+1; sec SEC_MOD-1 wraps to 0 with a carry to min; same for min to hour; hour HOUR_MOD-1 wraps to 0. Counting is frozen while i_mode==0 && i_set. Start/clear are ignored for the clock bank.
- Set (modes 0-2, i_set=1): an up edge increments field i_sel modulo its limit (59->0, HOUR_MOD-1->0). A down edge decrements (0->59, 0->HOUR_MOD-1). No carry/borrow into other fields. Up and down edges in the same cycle: no change. The edited bank does not count while in set.
- Timer bank: counts down on i_tick while its run flag is 1 and it is not in set. Sec borrows from min, min from hour.
  - The step from 00:00:01 to 00:00:00 clears the run flag and pulses o_timer_done.
  - A start edge while the bank is 00:00:00 leaves the run flag at 0.
- Stopwatch bank: counts up on i_tick while its run flag is 1 and it is not in set. Wraps HOUR_MOD-1:59:59 -> 0:00:00 and keeps running.
- Start/clear edges act only on the bank selected by i_mode (1 or 2). Clear zeroes all fields and the run flag. Clear and start edges in the same cycle: clear wins, flag 0.
- Run flags persist across mode changes; banks keep counting while not displayed.
- Mode 3: displays clock; set/start/clear ignored.
- Any unused i_sel value: no edit.
- Priority per bank per cycle: clear > set edit > tick.

## Timing
- Reset: all fields 0, both run flags 0, o_timer_done 0, edge/prev registers 0. Async assert, output effect immediate; normal operation from first clock edge after deassert.
- i_tick high at edge N: counted bank fields update at edge N; outputs valid after edge N.
- Button level first sampled high at edge N (prev low): edge registered at N, field/flag update at edge N+1.
- o_timer_done high for exactly the cycle following the edge at which the timer reaches zero. Timer idle at zero produces no further pulse.
- Outputs are a combinational mux of registered banks on i_mode; a mode change is visible in the same cycle.
- Reset mid-count or mid-set: everything returns to reset values; no pending edge survives.

## Test plan
- Clock 23:59:59, one tick -> 00:00:00; 00:00:58 -> ticks -> 00:00:59, 00:01:00.
- Mode 0, set, i_sel=0, sec=59, up edge -> 0 with min unchanged. Down edge from sec=0 -> 59. Hour 0 down -> 23. Ticks during set do not count.
- Mode 1, set timer 00:00:03, start edge, 3 ticks -> 00:00:00, o_timer_done one cycle after third tick. o_running 0, further ticks no change, start edge -> o_running stays 0.
- Mode 2, start, 5 ticks, switch to mode 0 for 5 ticks, back to mode 2 -> stopwatch 00:00:10, o_running 1. Clear edge -> 00:00:00, o_running 0.
- Up and down edges same cycle in set -> field unchanged. Clear and start same cycle -> bank zero, flag 0.
- Assert i_reset mid timer run at 00:01:30 -> all outputs 0 immediately; after release, ticks advance clock only.

Source files
------------

// File: rtl/time_keeper_multi_if.sv
// Control and display bundle between the button/tick front end and the
// time keeper. The master side drives the controls, the slave side (the
// time keeper) drives the displayed fields back.
interface time_keeper_multi_if #(
   parameter int W = 6
);
   logic         i_tick;
   logic [1:0]   i_mode;
   logic         i_set;
   logic [1:0]   i_sel;
   logic         i_up;
   logic         i_down;
   logic         i_start;
   logic         i_clear;
   logic [W-1:0] o_hour;
   logic [W-1:0] o_min;
   logic [W-1:0] o_sec;
   logic         o_running;
   logic         o_timer_done;

   modport master (
      output i_tick, i_mode, i_set, i_sel, i_up, i_down, i_start, i_clear,
      input  o_hour, o_min, o_sec, o_running, o_timer_done
   );

   modport slave (
      input  i_tick, i_mode, i_set, i_sel, i_up, i_down, i_start, i_clear,
      output o_hour, o_min, o_sec, o_running, o_timer_done
   );
endinterface

// File: rtl/time_keeper_multi.sv
// Three background time banks (wall clock, countdown timer, stopwatch).
// The bank chosen by i_mode is shown on the display fields; every bank
// keeps its own state and keeps counting while it is not displayed.
module time_keeper_multi #(
   parameter int W        = 6,
   parameter int SEC_MOD  = 60,
   parameter int HOUR_MOD = 24
) (
   input  logic                i_clk,
   input  logic                i_reset,
   time_keeper_multi_if.slave  bus
);

   localparam logic [W-1:0] SEC_MAX  = W'(SEC_MOD - 1);
   localparam logic [W-1:0] HOUR_MAX = W'(HOUR_MOD - 1);

   // Button bit positions inside the edge-detect vectors
   localparam int BTN_UP    = 0;
   localparam int BTN_DOWN  = 1;
   localparam int BTN_START = 2;
   localparam int BTN_CLEAR = 3;

   typedef struct packed {
      logic [W-1:0] h;
      logic [W-1:0] m;
      logic [W-1:0] s;
   } bank_t;

   function automatic logic [W-1:0] inc_f(input logic [W-1:0] v, input logic [W-1:0] max);
      return (v == max) ? '0 : v + W'(1);
   endfunction

   function automatic logic [W-1:0] dec_f(input logic [W-1:0] v, input logic [W-1:0] max);
      return (v == '0) ? max : v - W'(1);
   endfunction

   function automatic logic is_zero(input bank_t b);
      return (b.h == '0) && (b.m == '0) && (b.s == '0);
   endfunction

   // One second forward with carries; the hour field simply wraps
   function automatic bank_t tick_up(input bank_t b);
      bank_t r;
      r   = b;
      r.s = inc_f(b.s, SEC_MAX);
      if (b.s == SEC_MAX) begin
         r.m = inc_f(b.m, SEC_MAX);
         if (b.m == SEC_MAX) r.h = inc_f(b.h, HOUR_MAX);
      end
      return r;
   endfunction

   // One second backward with borrows; only called on a non-zero bank
   function automatic bank_t tick_down(input bank_t b);
      bank_t r;
      r   = b;
      r.s = dec_f(b.s, SEC_MAX);
      if (b.s == '0) begin
         r.m = dec_f(b.m, SEC_MAX);
         if (b.m == '0) r.h = dec_f(b.h, HOUR_MAX);
      end
      return r;
   endfunction

   // Set-mode edit of one field, modulo its own limit, never carrying;
   // simultaneous up and down cancel out
   function automatic bank_t edit_f(input bank_t b, input logic [1:0] sel,
                                    input logic up, input logic dn);
      bank_t r;
      r = b;
      if (up ^ dn) begin
         case (sel)
            2'd0:    r.s = up ? inc_f(b.s, SEC_MAX)  : dec_f(b.s, SEC_MAX);
            2'd1:    r.m = up ? inc_f(b.m, SEC_MAX)  : dec_f(b.m, SEC_MAX);
            2'd2:    r.h = up ? inc_f(b.h, HOUR_MAX) : dec_f(b.h, HOUR_MAX);
            default: r   = b;
         endcase
      end
      return r;
   endfunction

   logic [3:0] btn;
   logic [3:0] prev_q;
   logic [3:0] edge_q;

   assign btn = {bus.i_clear, bus.i_start, bus.i_down, bus.i_up};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_btn
         // Rising-edge detector per button; the edge is registered so the
         // action lands one clock after the level is first seen high
         always_ff @(posedge i_clk or negedge i_reset) begin
            if (!i_reset) begin
               prev_q[gi] <= 1'b0;
               edge_q[gi] <= 1'b0;
            end else begin
               prev_q[gi] <= btn[gi];
               edge_q[gi] <= btn[gi] & ~prev_q[gi];
            end
         end
      end
   endgenerate

   logic up_e, dn_e, st_e, clr_e;
   logic set_act;

   assign up_e    = edge_q[BTN_UP];
   assign dn_e    = edge_q[BTN_DOWN];
   assign st_e    = edge_q[BTN_START];
   assign clr_e   = edge_q[BTN_CLEAR];
   assign set_act = bus.i_set && (bus.i_mode != 2'd3);

   bank_t clk_q, clk_d;
   bank_t tmr_q, tmr_d;
   bank_t sw_q,  sw_d;
   logic  tmr_run_q, tmr_run_d;
   logic  sw_run_q,  sw_run_d;
   logic  done_q,    done_d;

   // Wall clock: edited in mode 0 set, otherwise counts every tick
   always_comb begin
      clk_d = clk_q;
      if (set_act && (bus.i_mode == 2'd0))
         clk_d = edit_f(clk_q, bus.i_sel, up_e, dn_e);
      else if (bus.i_tick)
         clk_d = tick_up(clk_q);
   end

   // Countdown timer: clear > edit > tick; expiry drops the run flag and
   // raises a one-cycle done pulse
   always_comb begin
      tmr_d     = tmr_q;
      tmr_run_d = tmr_run_q;
      done_d    = 1'b0;
      if ((bus.i_mode == 2'd1) && clr_e) begin
         tmr_d     = '0;
         tmr_run_d = 1'b0;
      end else begin
         if (set_act && (bus.i_mode == 2'd1)) begin
            tmr_d = edit_f(tmr_q, bus.i_sel, up_e, dn_e);
         end else if (bus.i_tick && tmr_run_q) begin
            if (is_zero(tmr_q)) begin
               // Edited down to zero while running: stop quietly
               tmr_run_d = 1'b0;
            end else begin
               tmr_d = tick_down(tmr_q);
               if (is_zero(tmr_d)) begin
                  tmr_run_d = 1'b0;
                  done_d    = 1'b1;
               end
            end
         end
         // Start toggles, but a timer sitting at zero cannot be started
         if ((bus.i_mode == 2'd1) && st_e)
            tmr_run_d = tmr_run_q ? 1'b0 : !is_zero(tmr_d);
      end
   end

   // Stopwatch: clear > edit > tick, wraps at the top of the hour range
   always_comb begin
      sw_d     = sw_q;
      sw_run_d = sw_run_q;
      if ((bus.i_mode == 2'd2) && clr_e) begin
         sw_d     = '0;
         sw_run_d = 1'b0;
      end else begin
         if (set_act && (bus.i_mode == 2'd2))
            sw_d = edit_f(sw_q, bus.i_sel, up_e, dn_e);
         else if (bus.i_tick && sw_run_q)
            sw_d = tick_up(sw_q);
         if ((bus.i_mode == 2'd2) && st_e)
            sw_run_d = ~sw_run_q;
      end
   end

   // Bank state registers
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         clk_q     <= '0;
         tmr_q     <= '0;
         sw_q      <= '0;
         tmr_run_q <= 1'b0;
         sw_run_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         clk_q     <= clk_d;
         tmr_q     <= tmr_d;
         sw_q      <= sw_d;
         tmr_run_q <= tmr_run_d;
         sw_run_q  <= sw_run_d;
         done_q    <= done_d;
      end
   end

   // Display mux: combinational so a mode change shows up at once
   always_comb begin
      bus.o_hour    = clk_q.h;
      bus.o_min     = clk_q.m;
      bus.o_sec     = clk_q.s;
      bus.o_running = 1'b0;
      case (bus.i_mode)
         2'd1: begin
            bus.o_hour    = tmr_q.h;
            bus.o_min     = tmr_q.m;
            bus.o_sec     = tmr_q.s;
            bus.o_running = tmr_run_q;
         end
         2'd2: begin
            bus.o_hour    = sw_q.h;
            bus.o_min     = sw_q.m;
            bus.o_sec     = sw_q.s;
            bus.o_running = sw_run_q;
         end
         default: ;
      endcase
   end

   assign bus.o_timer_done = done_q;

endmodule

// File: tb/tb_time_keeper_multi.sv
`timescale 1ns/1ps
// Directed bench for time_keeper_multi: a linear sequence of button,
// tick and mode steps, each followed by checks against hand-computed values.
module tb_time_keeper_multi;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   time_keeper_multi_if #(.W(6)) bus ();

   time_keeper_multi #(.W(6), .SEC_MOD(60), .HOUR_MOD(24)) dut (
      .i_clk   (clk),
      .i_reset (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_disp(input string tag, input int h, input int m, input int s, input int run);
      chk({tag, ".hour"}, 32'(bus.o_hour), 32'(h));
      chk({tag, ".min"},  32'(bus.o_min),  32'(m));
      chk({tag, ".sec"},  32'(bus.o_sec),  32'(s));
      chk({tag, ".run"},  32'(bus.o_running), 32'(run));
      $display("[TB] %s: display %0d:%0d:%0d run=%0d done=%0d",
               tag, bus.o_hour, bus.o_min, bus.o_sec, bus.o_running, bus.o_timer_done);
   endtask

   // b = {clear, start, down, up}; level for one edge, then released
   task automatic press(input logic [3:0] b);
      bus.i_up    = b[0];
      bus.i_down  = b[1];
      bus.i_start = b[2];
      bus.i_clear = b[3];
      step();
      bus.i_up    = 1'b0;
      bus.i_down  = 1'b0;
      bus.i_start = 1'b0;
      bus.i_clear = 1'b0;
      step();
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         bus.i_tick = 1'b1;
         step();
         bus.i_tick = 1'b0;
      end
   endtask

   initial begin
      bus.i_tick  = 1'b0;
      bus.i_mode  = 2'd0;
      bus.i_set   = 1'b0;
      bus.i_sel   = 2'd0;
      bus.i_up    = 1'b0;
      bus.i_down  = 1'b0;
      bus.i_start = 1'b0;
      bus.i_clear = 1'b0;

      // Reset state
      #12;
      chk_disp("reset", 0, 0, 0, 0);
      chk("reset.done", 32'(bus.o_timer_done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Clock set: field wraps without carry
      bus.i_set = 1'b1;
      bus.i_sel = 2'd0;
      press(4'b0010);
      chk_disp("clk_sec_down_0", 0, 0, 59, 0);
      press(4'b0001);
      chk_disp("clk_sec_up_59", 0, 0, 0, 0);
      press(4'b0010);
      bus.i_sel = 2'd2;
      press(4'b0010);
      chk_disp("clk_hour_down_0", 23, 0, 59, 0);
      bus.i_sel = 2'd1;
      press(4'b0010);
      chk_disp("clk_min_down_0", 23, 59, 59, 0);
      tick(2);
      chk_disp("clk_tick_in_set", 23, 59, 59, 0);
      press(4'b0011);
      chk_disp("clk_up_dn_same", 23, 59, 59, 0);
      bus.i_sel = 2'd3;
      press(4'b0001);
      chk_disp("clk_sel_none", 23, 59, 59, 0);

      // Clock rollover and carry
      bus.i_set = 1'b0;
      tick(1);
      chk_disp("clk_wrap_day", 0, 0, 0, 0);
      bus.i_set = 1'b1;
      bus.i_sel = 2'd0;
      press(4'b0010);
      press(4'b0010);
      bus.i_set = 1'b0;
      tick(1);
      chk_disp("clk_59", 0, 0, 59, 0);
      tick(1);
      chk_disp("clk_carry_min", 0, 1, 0, 0);

      // Timer: 3 s countdown with a single done pulse
      bus.i_mode = 2'd1;
      #1;
      chk_disp("tmr_idle", 0, 0, 0, 0);
      bus.i_set = 1'b1;
      bus.i_sel = 2'd0;
      for (int k = 0; k < 3; k++) press(4'b0001);
      bus.i_set = 1'b0;
      press(4'b0100);
      chk_disp("tmr_started", 0, 0, 3, 1);
      tick(2);
      chk_disp("tmr_at_1", 0, 0, 1, 1);
      chk("tmr_done_early", 32'(bus.o_timer_done), 32'd0);
      tick(1);
      chk_disp("tmr_expired", 0, 0, 0, 0);
      chk("tmr_done_pulse", 32'(bus.o_timer_done), 32'd1);
      step();
      chk("tmr_done_drop", 32'(bus.o_timer_done), 32'd0);
      tick(1);
      chk_disp("tmr_idle_tick", 0, 0, 0, 0);
      chk("tmr_no_repulse", 32'(bus.o_timer_done), 32'd0);
      press(4'b0100);
      chk_disp("tmr_start_at_zero", 0, 0, 0, 0);

      // Stopwatch runs in the background while the clock is shown
      bus.i_mode = 2'd2;
      press(4'b0100);
      tick(5);
      bus.i_mode = 2'd0;
      tick(5);
      chk_disp("clk_bg", 0, 1, 14, 0);
      bus.i_mode = 2'd2;
      #1;
      chk_disp("sw_bg_10", 0, 0, 10, 1);
      press(4'b1000);
      chk_disp("sw_clear", 0, 0, 0, 0);
      press(4'b0100);
      tick(2);
      press(4'b0100);
      chk_disp("sw_stopped", 0, 0, 2, 0);
      press(4'b1100);
      chk_disp("sw_clear_start", 0, 0, 0, 0);

      // Mode 3 shows the clock and ignores set/start
      bus.i_mode = 2'd3;
      bus.i_set  = 1'b1;
      press(4'b0001);
      press(4'b0100);
      chk_disp("mode3", 0, 1, 16, 0);
      bus.i_set  = 1'b0;
      bus.i_mode = 2'd2;
      #1;
      chk_disp("mode3_no_start", 0, 0, 0, 0);

      // Timer to 00:01:30, run, then asynchronous reset mid-count
      bus.i_mode = 2'd1;
      bus.i_set  = 1'b1;
      bus.i_sel  = 2'd1;
      press(4'b0001);
      bus.i_sel  = 2'd0;
      for (int k = 0; k < 30; k++) press(4'b0001);
      bus.i_set  = 1'b0;
      press(4'b0100);
      chk_disp("tmr_130", 0, 1, 30, 1);
      tick(1);
      chk_disp("tmr_129", 0, 1, 29, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_disp("rst_async_tmr", 0, 0, 0, 0);
      bus.i_mode = 2'd0;
      #1;
      chk_disp("rst_async_clk", 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.i_mode = 2'd1;
      step();
      tick(3);
      chk_disp("post_rst_tmr", 0, 0, 0, 0);
      bus.i_mode = 2'd2;
      #1;
      chk_disp("post_rst_sw", 0, 0, 0, 0);
      bus.i_mode = 2'd0;
      #1;
      chk_disp("post_rst_clk", 0, 0, 3, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
